// File: rtl/vga_box_gen.sv
// ---------------------------------------------------------------------------
// vga_box_gen
//
// Purpose:
//   Pixel source for the VGA sync/colour stage. It watches that stage's
//   hsync/vsync outputs, recovers the raster position from their falling
//   edges and drives a 1-bit pixel back into it. The picture is a solid
//   rectangle that bounces inside the active window, moving once per frame,
//   so the board has a moving test image without any framebuffer.
//
// Ports:
//   app_clk   in   pixel clock (same clock as the sync stage)
//   app_rst   in   synchronous active-high reset
//   hsync     in   horizontal sync from the sync stage, active low
//   vsync     in   vertical sync from the sync stage, active low
//   run       in   1 = box moves once per frame, 0 = box frozen
//   red_in    out  registered pixel value towards the sync stage
//   locked    out  raster position is valid
//   frame_stb out  one-cycle pulse for every vsync falling edge
//   box_x     out  current box left column (raster coordinates)
//   box_y     out  current box top row (raster coordinates)
//
// Timing notes:
//   The column counter lags the sync stage by one cycle and the pixel
//   register adds another, so red_in reflects column - 2. The sync stage
//   adds one more register, giving a fixed 3-column shift on screen. The
//   reported box_x/box_y stay in unshifted raster coordinates.
// ---------------------------------------------------------------------------
module vga_box_gen #(
    parameter int X_MIN  = 144,
    parameter int X_MAX  = 784,
    parameter int Y_MIN  = 31,
    parameter int Y_MAX  = 511,
    parameter int BOX_W  = 32,
    parameter int BOX_H  = 32,
    parameter int STEP_X = 2,
    parameter int STEP_Y = 1
) (
    input  logic       app_clk,
    input  logic       app_rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       run,
    output logic       red_in,
    output logic       locked,
    output logic       frame_stb,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lockState_t;

    // 11-bit versions of the geometry so every compare has headroom and
    // box_x + BOX_W can never wrap.
    localparam logic [10:0] X_LO     = 11'(X_MIN);
    localparam logic [10:0] X_HI     = 11'(X_MAX);
    localparam logic [10:0] Y_LO     = 11'(Y_MIN);
    localparam logic [10:0] Y_HI     = 11'(Y_MAX);
    localparam logic [10:0] X_RIGHT  = 11'(X_MAX - BOX_W);
    localparam logic [10:0] Y_BOTTOM = 11'(Y_MAX - BOX_H);
    localparam logic [10:0] BW       = 11'(BOX_W);
    localparam logic [10:0] BH       = 11'(BOX_H);
    localparam logic [10:0] SX       = 11'(STEP_X);
    localparam logic [10:0] SY       = 11'(STEP_Y);

    // 10-bit values loaded into the box position registers.
    localparam logic [9:0] X_HOME   = 10'(X_MIN);
    localparam logic [9:0] Y_HOME   = 10'(Y_MIN);
    localparam logic [9:0] X_STOP   = 10'(X_MAX - BOX_W);
    localparam logic [9:0] Y_STOP   = 10'(Y_MAX - BOX_H);
    localparam logic [9:0] SX10     = 10'(STEP_X);
    localparam logic [9:0] SY10     = 10'(STEP_Y);
    localparam logic [9:0] CNT_SAT  = 10'h3FF;

    logic       r_hsQ;
    logic       r_vsQ;
    logic [9:0] r_x;
    logic [9:0] r_y;
    lockState_t r_state;
    logic [9:0] r_boxX;
    logic [9:0] r_boxY;
    logic       r_dx;
    logic       r_dy;
    logic       r_redIn;
    logic       r_frameStb;

    logic        w_hFall;
    logic        w_vFall;
    logic [10:0] w_xExt;
    logic [10:0] w_yExt;
    logic [10:0] w_bxExt;
    logic [10:0] w_byExt;
    logic        w_inWindow;
    logic        w_inBox;
    logic        w_inside;
    logic [9:0]  w_nextX;
    logic [9:0]  w_nextY;
    logic        w_nextDx;
    logic        w_nextDy;

    // A vertical edge only counts when it lines up with a horizontal edge,
    // which is how the sync stage produces it; a stray vsync glitch between
    // line starts is ignored.
    assign w_hFall = r_hsQ & ~hsync;
    assign w_vFall = w_hFall & r_vsQ & ~vsync;

    assign w_xExt  = {1'b0, r_x};
    assign w_yExt  = {1'b0, r_y};
    assign w_bxExt = {1'b0, r_boxX};
    assign w_byExt = {1'b0, r_boxY};

    // A pixel is lit only when it lies in the visible window and inside the
    // box. Both tests are needed because the counters keep running through
    // blanking and could otherwise alias onto the box rectangle.
    assign w_inWindow = (w_xExt >= X_LO) && (w_xExt < X_HI) &&
                        (w_yExt >= Y_LO) && (w_yExt < Y_HI);
    assign w_inBox    = (w_xExt >= w_bxExt) && (w_xExt < (w_bxExt + BW)) &&
                        (w_yExt >= w_byExt) && (w_yExt < (w_byExt + BH));
    assign w_inside   = w_inWindow & w_inBox;

    // Next box position for one frame step. When the next step would reach
    // or pass a wall, the box is clamped onto the wall and the direction
    // flips in the same step, so it never leaves the window.
    always_comb begin
        w_nextX  = r_boxX;
        w_nextDx = r_dx;
        if (!r_dx) begin
            if ((w_bxExt + SX) >= X_RIGHT) begin
                w_nextX  = X_STOP;
                w_nextDx = 1'b1;
            end else begin
                w_nextX  = r_boxX + SX10;
            end
        end else begin
            if (w_bxExt <= (X_LO + SX)) begin
                w_nextX  = X_HOME;
                w_nextDx = 1'b0;
            end else begin
                w_nextX  = r_boxX - SX10;
            end
        end
    end

    // Vertical counterpart of the step above, with its own direction flag.
    always_comb begin
        w_nextY  = r_boxY;
        w_nextDy = r_dy;
        if (!r_dy) begin
            if ((w_byExt + SY) >= Y_BOTTOM) begin
                w_nextY  = Y_STOP;
                w_nextDy = 1'b1;
            end else begin
                w_nextY  = r_boxY + SY10;
            end
        end else begin
            if (w_byExt <= (Y_LO + SY)) begin
                w_nextY  = Y_HOME;
                w_nextDy = 1'b0;
            end else begin
                w_nextY  = r_boxY - SY10;
            end
        end
    end

    // Previous-cycle copies of the sync inputs for edge detection. They
    // reset high (idle) so that a sync line already low after reset is not
    // mistaken for a fresh edge.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_hsQ <= 1'b1;
            r_vsQ <= 1'b1;
        end else begin
            r_hsQ <= hsync;
            r_vsQ <= vsync;
        end
    end

    // Raster position counters. Both restart on their sync edge and
    // saturate at all-ones, which the lock watchdog uses as "no line start
    // seen for too long". The row counter only moves on line starts, in the
    // same cycle the column counter clears, so rows never skew.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_x <= CNT_SAT;
            r_y <= CNT_SAT;
        end else begin
            if (w_hFall) begin
                r_x <= 10'd0;
            end else if (r_x != CNT_SAT) begin
                r_x <= r_x + 10'd1;
            end
            if (w_vFall) begin
                r_y <= 10'd0;
            end else if (w_hFall && (r_y != CNT_SAT)) begin
                r_y <= r_y + 10'd1;
            end
        end
    end

    // Lock state machine plus box motion. Motion looks at the state before
    // this edge, so the frame edge that establishes lock does not also move
    // the box. Moves happen on the frame edge itself, i.e. during vertical
    // blanking, so a frame is never drawn with two different positions.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_state <= UNLOCKED;
            r_boxX  <= X_HOME;
            r_boxY  <= Y_HOME;
            r_dx    <= 1'b0;
            r_dy    <= 1'b0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if (w_vFall) begin
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (r_x == CNT_SAT) begin
                        r_state <= UNLOCKED;
                    end
                end
                default: begin
                    r_state <= UNLOCKED;
                end
            endcase
            if (w_vFall && run && (r_state == LOCKED)) begin
                r_boxX <= w_nextX;
                r_boxY <= w_nextY;
                r_dx   <= w_nextDx;
                r_dy   <= w_nextDy;
            end
        end
    end

    // Registered outputs towards the sync stage. The pixel is forced dark
    // while unlocked so a lost or absent sync never paints garbage; the
    // frame strobe follows every frame edge regardless of lock or run.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_redIn    <= 1'b0;
            r_frameStb <= 1'b0;
        end else begin
            r_redIn    <= (r_state == LOCKED) & w_inside;
            r_frameStb <= w_vFall;
        end
    end

    assign red_in    = r_redIn;
    assign frame_stb = r_frameStb;
    assign locked    = (r_state == LOCKED);
    assign box_x     = r_boxX;
    assign box_y     = r_boxY;

endmodule

// File: tb/tb_vga_box_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_box_gen
//
// Drives vga_box_gen with hand-built sync waveforms. Lines and frames are
// shortened (the design only reacts to sync edges) so that hundreds of
// frames fit in a short run. Expected values are hand computed from the
// box geometry: 32x32 box, window columns 144..783, rows 31..510.
// ---------------------------------------------------------------------------
module tb_vga_box_gen;

    logic       app_clk;
    logic       app_rst;
    logic       hsync;
    logic       vsync;
    logic       run;
    logic       red_in;
    logic       locked;
    logic       frame_stb;
    logic [9:0] box_x;
    logic [9:0] box_y;

    int checks;
    int failures;

    // Per-line observations gathered by applyStimulus.
    int redCount;
    int firstRed;
    int lineStb;
    int lineStbIdx;
    int firstUnlock;
    int stbTotal;

    typedef struct {
        int row;
        int expCount;
        int expFirst;
    } rowVec_t;

    typedef struct {
        int frame;
        int expX;
        int expY;
    } moveVec_t;

    rowVec_t  rowTab[6];
    moveVec_t moveTab[11];

    vga_box_gen dut (
        .app_clk   (app_clk),
        .app_rst   (app_rst),
        .hsync     (hsync),
        .vsync     (vsync),
        .run       (run),
        .red_in    (red_in),
        .locked    (locked),
        .frame_stb (frame_stb),
        .box_x     (box_x),
        .box_y     (box_y)
    );

    // 100 MHz clock; the design only cares about edges, not the rate.
    initial begin
        app_clk = 1'b0;
        forever #5 app_clk = ~app_clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one raster line of len cycles: hsync low for lowLen cycles,
    // vsync held at vsVal for the whole line (it changes together with the
    // hsync fall, as a real sync stage does). Outputs are sampled 1 ns after
    // each rising edge; index n is the n-th edge counted from the line start.
    task automatic applyStimulus(input int len, input int lowLen, input logic vsVal);
        redCount    = 0;
        firstRed    = -1;
        lineStb     = 0;
        lineStbIdx  = -1;
        firstUnlock = -1;
        vsync       = vsVal;
        for (int n = 0; n < len; n++) begin
            hsync = (n < lowLen) ? 1'b0 : 1'b1;
            @(posedge app_clk);
            #1;
            if (red_in) begin
                redCount++;
                if (firstRed < 0) firstRed = n;
            end
            if (frame_stb) begin
                lineStb++;
                stbTotal++;
                if (lineStbIdx < 0) lineStbIdx = n;
            end
            if (!locked && (firstUnlock < 0)) firstUnlock = n;
        end
    endtask

    // A short frame: two lines with vsync low, then one with vsync high.
    task automatic runShortFrame();
        applyStimulus(8, 2, 1'b0);
        applyStimulus(8, 2, 1'b0);
        applyStimulus(8, 2, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        stbTotal = 0;

        // Rows of the placement frame: box rows 31..62, columns 144..175,
        // which land on line indices 145..176 after the two register stages.
        rowTab[0] = '{30, 0, -1};
        rowTab[1] = '{31, 32, 145};
        rowTab[2] = '{45, 32, 145};
        rowTab[3] = '{62, 32, 145};
        rowTab[4] = '{63, 0, -1};
        rowTab[5] = '{2, 0, -1};

        // Box position after the given number of moving frames.
        moveTab[0]  = '{1, 146, 32};
        moveTab[1]  = '{2, 148, 33};
        moveTab[2]  = '{303, 750, 334};
        moveTab[3]  = '{304, 752, 335};
        moveTab[4]  = '{305, 750, 336};
        moveTab[5]  = '{448, 464, 479};
        moveTab[6]  = '{449, 462, 478};
        moveTab[7]  = '{450, 460, 477};
        moveTab[8]  = '{607, 146, 320};
        moveTab[9]  = '{608, 144, 319};
        moveTab[10] = '{609, 146, 318};

        // Reset held for three cycles.
        app_rst = 1'b1;
        hsync   = 1'b1;
        vsync   = 1'b1;
        run     = 1'b1;
        repeat (3) @(posedge app_clk);
        #1;
        checkOutput("rst_red_in", int'(red_in), 0);
        checkOutput("rst_locked", int'(locked), 0);
        checkOutput("rst_frame_stb", int'(frame_stb), 0);
        checkOutput("rst_box_x", int'(box_x), 144);
        checkOutput("rst_box_y", int'(box_y), 31);
        app_rst = 1'b0;

        // Lines without a frame edge must not lock or light pixels.
        applyStimulus(200, 20, 1'b1);
        applyStimulus(200, 20, 1'b1);
        checkOutput("prelock_locked", int'(locked), 0);
        checkOutput("prelock_red", redCount, 0);

        // Lock frame with 200-cycle lines; check the box footprint per row.
        for (int row = 0; row < 70; row++) begin
            applyStimulus(200, 20, (row < 2) ? 1'b0 : 1'b1);
            if (row == 0) begin
                checkOutput("lock_stb_count", lineStb, 1);
                checkOutput("lock_stb_index", lineStbIdx, 0);
                checkOutput("lock_locked", int'(locked), 1);
            end
            for (int i = 0; i < 6; i++) begin
                if (rowTab[i].row == row) begin
                    checkOutput($sformatf("row%0d_red_count", row), redCount, rowTab[i].expCount);
                    checkOutput($sformatf("row%0d_red_first", row), firstRed, rowTab[i].expFirst);
                end
            end
        end
        checkOutput("lock_nomove_x", int'(box_x), 144);
        checkOutput("lock_nomove_y", int'(box_y), 31);

        // Bounce: 609 moving frames, spot-checked at the wall crossings.
        stbTotal = 0;
        for (int f = 1; f <= 609; f++) begin
            runShortFrame();
            for (int i = 0; i < 11; i++) begin
                if (moveTab[i].frame == f) begin
                    checkOutput($sformatf("frame%0d_box_x", f), int'(box_x), moveTab[i].expX);
                    checkOutput($sformatf("frame%0d_box_y", f), int'(box_y), moveTab[i].expY);
                end
            end
        end
        checkOutput("bounce_stb_total", stbTotal, 609);

        // Freeze: run dropped in the middle of a frame.
        applyStimulus(8, 2, 1'b1);
        run      = 1'b0;
        stbTotal = 0;
        repeat (3) runShortFrame();
        checkOutput("freeze_box_x", int'(box_x), 146);
        checkOutput("freeze_box_y", int'(box_y), 318);
        checkOutput("freeze_stb_total", stbTotal, 3);

        // Watchdog: one line start, then hsync stuck high.
        run = 1'b1;
        applyStimulus(1100, 2, 1'b1);
        checkOutput("wdog_unlock_index", firstUnlock, 1024);
        checkOutput("wdog_red", redCount, 0);
        checkOutput("wdog_locked", int'(locked), 0);

        // Sync restored without a frame edge: still unlocked.
        applyStimulus(200, 20, 1'b1);
        applyStimulus(200, 20, 1'b1);
        checkOutput("restore_locked", int'(locked), 0);
        checkOutput("restore_red", redCount, 0);

        // Relock frame does not move the box; the following frame does.
        runShortFrame();
        checkOutput("relock_locked", int'(locked), 1);
        checkOutput("relock_box_x", int'(box_x), 146);
        checkOutput("relock_box_y", int'(box_y), 318);
        runShortFrame();
        checkOutput("after_relock_box_x", int'(box_x), 148);
        checkOutput("after_relock_box_y", int'(box_y), 317);

        // Reset in the middle of a line.
        applyStimulus(5, 2, 1'b1);
        app_rst = 1'b1;
        @(posedge app_clk);
        #1;
        app_rst = 1'b0;
        checkOutput("midrst_locked", int'(locked), 0);
        checkOutput("midrst_red", int'(red_in), 0);
        checkOutput("midrst_box_x", int'(box_x), 144);
        checkOutput("midrst_box_y", int'(box_y), 31);
        applyStimulus(8, 2, 1'b1);
        checkOutput("midrst_still_unlocked", int'(locked), 0);
        runShortFrame();
        checkOutput("midrst_relock", int'(locked), 1);
        checkOutput("midrst_relock_box_x", int'(box_x), 144);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_box_gen.md
# vga_box_gen

Pixel source sitting directly upstream of the VGA sync/colour stage. It watches that stage's `hsync`/`vsync` outputs, recovers the raster position, and drives that stage's 1-bit `red_in` pixel input. The image is a solid rectangle that bounces inside the 640x480 active window, moving once per frame. It gives the board a self-contained moving test image with no framebuffer.

## Interface
- `X_MIN`, 144: first active raster column.
- `X_MAX`, 784: last active column + 1.
- `Y_MIN`, 31: first active raster row.
- `Y_MAX`, 511: last active row + 1.
- `BOX_W`, 32: box width in pixels, 1..(X_MAX-X_MIN).
- `BOX_H`, 32: box height in lines, 1..(Y_MAX-Y_MIN).
- `STEP_X`, 2: horizontal pixels moved per frame, ≥1.
- `STEP_Y`, 1: vertical lines moved per frame, ≥1.
- `app_clk` in 1: pixel clock, same clock as the sync stage. One clock; all logic is on its rising edge.
- `app_rst` in 1: synchronous, active-high reset.
- `hsync` in 1: from the sync stage, active low, 96 cycles low per 800-cycle line.
- `vsync` in 1: from the sync stage, active low, 2 lines low per 521-line frame.
- `run` in 1: 1 = box moves each frame; 0 = box is frozen.
- `red_in` out 1: pixel to the sync stage (registered).
- `locked` out 1: raster position is valid.
- `frame_stb` out 1: one-cycle pulse on each vsync falling edge.
- `box_x` out 10: current box left column (raster coordinates).
- `box_y` out 10: current box top row (raster coordinates).

## Operation
- **Edge detect**
  - `hs_q` and `vs_q` hold the previous-cycle `hsync` and `vsync`.
  - `h_fall = hs_q & ~hsync`.
  - `v_fall = h_fall & vs_q & ~vsync`.
- **Column counter `x_r`** (10 bits)
  - `h_fall`: load 0.
  - Otherwise: increment, saturating at 1023.
- **Row counter `y_r`** (10 bits)
  - `v_fall`: load 0.
  - `h_fall` without `v_fall`: increment, saturating at 1023.
  - Otherwise: hold.
- **Lock state machine**, states UNLOCKED / LOCKED:
  - UNLOCKED→LOCKED on `v_fall`.
  - LOCKED→UNLOCKED when `x_r == 1023`, i.e. no hsync edge for a line period (watchdog).
  - `app_rst` forces UNLOCKED.
  - `locked` = (state == LOCKED).
- **Pixel decision:** `red_in <= locked & inside`, where `inside` requires all of:
  - `X_MIN ≤ x_r < X_MAX` and `Y_MIN ≤ y_r < Y_MAX`;
  - `box_x ≤ x_r < box_x+BOX_W` and `box_y ≤ y_r < box_y+BOX_H`.
  - Compares use 11-bit arithmetic so there is no wrap.
- **Motion**, on `v_fall` only, and only if `run` = 1 and the state was already LOCKED before this edge:
  - The first `v_fall` after reset or unlock only locks; the box does not move on it.
  - Right (`dx`=0): if `box_x + STEP_X ≥ X_MAX-BOX_W`, set `box_x = X_MAX-BOX_W` and `dx` = 1; else `box_x += STEP_X`.
  - Left (`dx`=1): if `box_x ≤ X_MIN + STEP_X`, set `box_x = X_MIN` and `dx` = 0; else `box_x -= STEP_X`.
  - Y axis behaves identically with `dy`, `STEP_Y`, `Y_MIN`, `Y_MAX-BOX_H`.
  - X and Y update in the same cycle; both may bounce simultaneously.
- **Frame strobe:** `frame_stb` = registered `v_fall`, independent of `run` and of lock state.

## Timing
- **Reset values:**
  - `red_in` = 0, `locked` = 0, `frame_stb` = 0.
  - `box_x` = `X_MIN`, `box_y` = `Y_MIN`, `dx` = `dy` = 0.
  - `x_r` = `y_r` = 1023.
  - `hs_q` = `vs_q` = 1.
- **Position lag:** `x_r` equals the sync-stage column − 1.
- **Pixel latency:** `red_in` reflects column − 2. The sync stage adds one register, so a box pixel at raster column c appears on `red` at column c+3. This fixed 3-column shift is accepted; `box_x` is reported in raster coordinates, unshifted.
- **Row alignment:** `y_r` changes together with `x_r`, so no row skew is visible.
- **Box position timing:** `box_x`/`box_y` change one cycle after `v_fall`, i.e. during vsync, outside the active area. No tearing.
- **`run` sampling:** `run` is sampled only in the `v_fall` cycle.
- **Reset mid-frame:** on the next edge all state returns to reset values. Relock occurs on the next vsync fall; `red_in` stays 0 until then.

## Test plan
- **Reset:** hold `app_rst` 3 cycles → `red_in`=0, `locked`=0, `box_x`=144, `box_y`=31, `frame_stb`=0.
- **Lock:** drive from the real sync stage; at the first `v_fall` → `locked`=1 and `frame_stb` pulses once; `box_x` stays 144.
- **Pixel placement:** at the first locked frame, `run`=0 → sync-stage `red`=3'b111 exactly on rows 31..62, columns 147..178; 0 elsewhere.
- **Bounce:** `run`=1 → `box_x` increments by 2 per frame and reaches 752 after 304 moving frames, with `dx`→1. The next frame gives 750. `box_y` reaches 479 after 448 frames, then decrements.
- **Watchdog:** once locked, hold `hsync`=1 for 1100 cycles → `locked` drops at `x_r`=1023 and `red_in` stays 0. Restore sync → relock at the next `v_fall`.
- **Freeze:** toggle `run` to 0 mid-frame → `box_x`/`box_y` stay constant on subsequent frames while `frame_stb` keeps pulsing every 416800 cycles.
